// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice.
// Holds the op encodings, the instruction field positions, the register
// count and the layout of the decoded X-stage entry.
package alu_pkg;

   localparam int NREGS = 4;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_NOT = 4'd2;
   localparam logic [3:0] OP_XOR = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;

   // Common: bit 8 selects S-type (1) or C-type (0)
   localparam int I_TYPE  = 8;

   // C-type fields
   localparam int C_OP_HI = 7;
   localparam int C_OP_LO = 4;
   localparam int C_RD_HI = 3;
   localparam int C_RD_LO = 2;
   localparam int C_RS_HI = 1;
   localparam int C_RS_LO = 0;

   // S-type fields
   localparam int S_DIR   = 7;
   localparam int S_RD_HI = 6;
   localparam int S_RD_LO = 5;
   localparam int S_SH_HI = 4;
   localparam int S_SH_LO = 2;

   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic [1:0] rd;
      logic       s_or_c;
      logic       shift_dir;
      logic [3:0] op;
      logic [7:0] in1;
      logic [7:0] in2;
   } x_stage_t;

endpackage

// File: rtl/reg_file4.sv
// 4x8 register file with two combinational read ports and two write ports.
// Ports:
//   clk, rst_n               clock, async active-low reset (all regs -> REG_INIT)
//   rd_addr_a/rd_data_a      read port A
//   rd_addr_b/rd_data_b      read port B
//   alu_wr_en/addr/data      write port for retiring ALU results
//   ext_wr_en/addr/data      external loader write port
// When both write ports hit the same address on one edge, the external
// write is kept because it is the newer event.
module reg_file4
   import alu_pkg::*;
#(
   parameter logic [7:0] REG_INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] rd_addr_a,
   output logic [7:0] rd_data_a,
   input  logic [1:0] rd_addr_b,
   output logic [7:0] rd_data_b,
   input  logic       alu_wr_en,
   input  logic [1:0] alu_wr_addr,
   input  logic [7:0] alu_wr_data,
   input  logic       ext_wr_en,
   input  logic [1:0] ext_wr_addr,
   input  logic [7:0] ext_wr_data
);

   logic [7:0] regs [NREGS];

   assign rd_data_a = regs[rd_addr_a];
   assign rd_data_b = regs[rd_addr_b];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= REG_INIT;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (ext_wr_en && ext_wr_addr == 2'(i)) begin
               regs[i] <= ext_wr_data;
            end else if (alu_wr_en && alu_wr_addr == 2'(i)) begin
               regs[i] <= alu_wr_data;
            end
         end
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of alu/alu_control.
// Decodes one 9-bit instruction per cycle into ALU control fields, reads
// operands (with forwarding from the in-flight X entry) and retires the
// returned ALU result into the register file.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   instr_valid, instr, instr_ready  instruction handshake (ready = !ext_wr_en)
//   ext_wr_en/addr/data              external register load
//   s_or_c, shift_dir, op_in         control to alu_control (from X register)
//   alu_in1, alu_in2                 operands to alu (from X register)
//   alu_out                          combinational ALU result
//   wb_valid, wb_rd, wb_data         registered writeback report
//   illegal                          registered pulse for a retired illegal op
module alu_issue
   import alu_pkg::*;
#(
   parameter logic [7:0] REG_INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   input  logic [8:0] instr,
   output logic       instr_ready,
   input  logic       ext_wr_en,
   input  logic [1:0] ext_wr_addr,
   input  logic [7:0] ext_wr_data,
   output logic       s_or_c,
   output logic       shift_dir,
   output logic [3:0] op_in,
   output logic [7:0] alu_in1,
   output logic [7:0] alu_in2,
   input  logic [7:0] alu_out,
   output logic       wb_valid,
   output logic [1:0] wb_rd,
   output logic [7:0] wb_data,
   output logic       illegal
);

   x_stage_t   x_q;
   x_stage_t   x_d;
   logic       accept;
   logic       is_shift;
   logic       dec_illegal;
   logic [1:0] dec_rd;
   logic [1:0] dec_rs;
   logic [7:0] rf_rd_data;
   logic [7:0] rf_rs_data;
   logic [7:0] opnd_rd;
   logic [7:0] opnd_rs;
   logic       fwd_ok;
   logic       retire;

   assign instr_ready = rst_n & ~ext_wr_en;
   assign accept      = instr_valid & instr_ready;

   assign is_shift    = instr[I_TYPE];
   assign dec_rd      = is_shift ? instr[S_RD_HI:S_RD_LO] : instr[C_RD_HI:C_RD_LO];
   assign dec_rs      = instr[C_RS_HI:C_RS_LO];
   assign dec_illegal = !is_shift && (instr[C_OP_HI:C_OP_LO] > OP_SUB);

   // An illegal X entry never writes back, so it must not be forwarded.
   assign fwd_ok  = x_q.valid & ~x_q.illegal;
   assign opnd_rd = (fwd_ok && x_q.rd == dec_rd) ? alu_out : rf_rd_data;
   assign opnd_rs = (fwd_ok && x_q.rd == dec_rs) ? alu_out : rf_rs_data;

   assign retire  = x_q.valid & ~x_q.illegal;

   reg_file4 #(
      .REG_INIT (REG_INIT)
   ) u_rf (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_addr_a   (dec_rd),
      .rd_data_a   (rf_rd_data),
      .rd_addr_b   (dec_rs),
      .rd_data_b   (rf_rs_data),
      .alu_wr_en   (retire),
      .alu_wr_addr (x_q.rd),
      .alu_wr_data (alu_out),
      .ext_wr_en   (ext_wr_en),
      .ext_wr_addr (ext_wr_addr),
      .ext_wr_data (ext_wr_data)
   );

   // Non-valid fields are held when nothing is accepted so the ALU-facing
   // outputs keep their previous values while X is empty.
   always_comb begin
      x_d       = x_q;
      x_d.valid = 1'b0;
      if (accept) begin
         x_d.valid     = 1'b1;
         x_d.illegal   = dec_illegal;
         x_d.rd        = dec_rd;
         x_d.s_or_c    = is_shift;
         x_d.shift_dir = is_shift & instr[S_DIR];
         x_d.op        = is_shift ? 4'b0000 : instr[C_OP_HI:C_OP_LO];
         x_d.in1       = opnd_rd;
         x_d.in2       = is_shift ? {5'b0, instr[S_SH_HI:S_SH_LO]} : opnd_rs;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q      <= '0;
         wb_valid <= 1'b0;
         wb_rd    <= 2'b00;
         wb_data  <= 8'h00;
         illegal  <= 1'b0;
      end else begin
         x_q      <= x_d;
         wb_valid <= retire;
         illegal  <= x_q.valid & x_q.illegal;
         if (retire) begin
            wb_rd   <= x_q.rd;
            wb_data <= alu_out;
         end
      end
   end

   assign s_or_c    = x_q.s_or_c;
   assign shift_dir = x_q.shift_dir;
   assign op_in     = x_q.op;
   assign alu_in1   = x_q.in1;
   assign alu_in2   = x_q.in2;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

   logic       clk;
   logic       rst_n;
   logic       instr_valid;
   logic [8:0] instr;
   logic       instr_ready;
   logic       ext_wr_en;
   logic [1:0] ext_wr_addr;
   logic [7:0] ext_wr_data;
   logic       s_or_c;
   logic       shift_dir;
   logic [3:0] op_in;
   logic [7:0] alu_in1;
   logic [7:0] alu_in2;
   logic [7:0] alu_out;
   logic       wb_valid;
   logic [1:0] wb_rd;
   logic [7:0] wb_data;
   logic       illegal;

   alu_issue #(.REG_INIT(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .ext_wr_en   (ext_wr_en),
      .ext_wr_addr (ext_wr_addr),
      .ext_wr_data (ext_wr_data),
      .s_or_c      (s_or_c),
      .shift_dir   (shift_dir),
      .op_in       (op_in),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_out     (alu_out),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream ALU stand-in; unused ops return a marker value so a wrong
   // forward from an illegal entry is visible.
   function automatic logic [7:0] alu_fn(input logic s, input logic dir, input logic [3:0] op,
                                         input logic [7:0] a, input logic [7:0] b);
      if (s) return dir ? (a >> b) : (a << b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return ~a;
         4'd3:    return a ^ b;
         4'd4:    return a + b;
         4'd5:    return a - b;
         default: return 8'hEE;
      endcase
   endfunction

   assign alu_out = alu_fn(s_or_c, shift_dir, op_in, alu_in1, alu_in2);

   typedef struct packed {
      logic       valid;
      logic       ill;
      logic       s;
      logic       dir;
      logic [3:0] op;
      logic [1:0] rd;
      logic [7:0] in1;
      logic [7:0] in2;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [8:0] ins;
      logic [7:0] in1;
      logic [7:0] in2;
      logic       ill;
      logic [1:0] rd;
      logic [7:0] data;
   } vec_t;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] m_regs [4];
   exp_t       st1;
   exp_t       st2;
   vec_t       vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural model: an accepted instruction executes immediately on the
   // model register array, in program order; external loads apply after it.
   task automatic model_exec(input logic [8:0] ins, output exp_t e);
      int a;
      int b;
      int r;
      e       = '0;
      e.valid = 1'b1;
      r       = 0;
      if (ins[8]) begin
         e.s   = 1'b1;
         e.dir = ins[7];
         e.op  = 4'd0;
         e.rd  = ins[6:5];
         a     = int'(m_regs[e.rd]);
         b     = int'(ins[4:2]);
         r     = ins[7] ? (a >> b) : (a << b);
      end else begin
         e.op  = ins[7:4];
         e.rd  = ins[3:2];
         a     = int'(m_regs[e.rd]);
         b     = int'(m_regs[ins[1:0]]);
         case (ins[7:4])
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = ~a;
            4'd3:    r = a ^ b;
            4'd4:    r = a + b;
            4'd5:    r = a - b;
            default: e.ill = 1'b1;
         endcase
      end
      e.in1  = 8'(a);
      e.in2  = 8'(b);
      e.data = 8'(r);
      if (!e.ill) m_regs[e.rd] = e.data;
   endtask

   task automatic check_outputs();
      if (st1.valid && !st1.ill) begin
         chk("s_or_c",    32'(s_or_c),    32'(st1.s));
         chk("shift_dir", 32'(shift_dir), 32'(st1.dir));
         chk("op_in",     32'(op_in),     32'(st1.op));
         chk("alu_in1",   32'(alu_in1),   32'(st1.in1));
         chk("alu_in2",   32'(alu_in2),   32'(st1.in2));
      end
      chk("wb_valid", 32'(wb_valid), 32'(st2.valid && !st2.ill));
      chk("illegal",  32'(illegal),  32'(st2.valid && st2.ill));
      if (st2.valid && !st2.ill) begin
         chk("wb_rd",   32'(wb_rd),   32'(st2.rd));
         chk("wb_data", 32'(wb_data), 32'(st2.data));
      end
   endtask

   // Called one unit after a rising edge; drives one cycle and checks the result.
   task automatic drive(input logic v, input logic [8:0] ins, input logic ewe,
                        input logic [1:0] ea, input logic [7:0] ed);
      exp_t e;
      instr_valid = v;
      instr       = ins;
      ext_wr_en   = ewe;
      ext_wr_addr = ea;
      ext_wr_data = ed;
      #1;
      chk("instr_ready", 32'(instr_ready), 32'(!ewe));
      e = '0;
      if (v && !ewe) model_exec(ins, e);
      if (ewe) m_regs[ea] = ed;
      @(posedge clk);
      st2 = st1;
      st1 = e;
      #1;
      check_outputs();
   endtask

   task automatic idle();
      drive(1'b0, 9'h000, 1'b0, 2'd0, 8'h00);
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      drive(1'b0, 9'h000, 1'b1, a, d);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"},   32'(instr_ready), 32'd0);
      chk({tag, "_outs"},    32'({s_or_c, shift_dir, op_in, alu_in1, alu_in2}), 32'd0);
      chk({tag, "_wb"},      32'({wb_valid, wb_rd, wb_data, illegal}), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      ext_wr_en   = 1'b0;
      ext_wr_addr = '0;
      ext_wr_data = '0;
      st1         = '0;
      st2         = '0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

      vecs[0] = '{9'h041, 8'h05, 8'h03, 1'b0, 2'd0, 8'h08};
      vecs[1] = '{9'h00B, 8'hF0, 8'h0F, 1'b0, 2'd2, 8'h00};
      vecs[2] = '{9'h01B, 8'h00, 8'h0F, 1'b0, 2'd2, 8'h0F};
      vecs[3] = '{9'h03C, 8'h0F, 8'h08, 1'b0, 2'd3, 8'h07};
      vecs[4] = '{9'h024, 8'h03, 8'h08, 1'b0, 2'd1, 8'hFC};
      vecs[5] = '{9'h05D, 8'h07, 8'hFC, 1'b0, 2'd3, 8'h0B};
      vecs[6] = '{9'h1AC, 8'hFC, 8'h03, 1'b0, 2'd1, 8'h1F};
      vecs[7] = '{9'h108, 8'h08, 8'h02, 1'b0, 2'd0, 8'h20};
      vecs[8] = '{9'h091, 8'h20, 8'h1F, 1'b1, 2'd0, 8'h00};
      vecs[9] = '{9'h040, 8'h20, 8'h20, 1'b0, 2'd0, 8'h40};

      #1;
      check_all_zero("reset");
      #11 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: one instruction then one idle cycle each, from known registers.
      load(2'd0, 8'h05);
      load(2'd1, 8'h03);
      load(2'd2, 8'hF0);
      load(2'd3, 8'h0F);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, vecs[i].ins, 1'b0, 2'd0, 8'h00);
         if (!vecs[i].ill) begin
            chk($sformatf("vec%0d_in1", i), 32'(alu_in1), 32'(vecs[i].in1));
            chk($sformatf("vec%0d_in2", i), 32'(alu_in2), 32'(vecs[i].in2));
         end
         idle();
         chk($sformatf("vec%0d_wb_valid", i), 32'(wb_valid), 32'(!vecs[i].ill));
         chk($sformatf("vec%0d_illegal", i),  32'(illegal),  32'(vecs[i].ill));
         if (!vecs[i].ill) begin
            chk($sformatf("vec%0d_wb_rd", i),   32'(wb_rd),   32'(vecs[i].rd));
            chk($sformatf("vec%0d_wb_data", i), 32'(wb_data), 32'(vecs[i].data));
         end
      end

      // ADD then dependent SUB back-to-back.
      load(2'd0, 8'h05);
      load(2'd1, 8'h03);
      drive(1'b1, 9'h041, 1'b0, 2'd0, 8'h00);
      chk("add_op_in", 32'(op_in), 32'd4);
      chk("add_in1", 32'(alu_in1), 32'h05);
      chk("add_in2", 32'(alu_in2), 32'h03);
      drive(1'b1, 9'h051, 1'b0, 2'd0, 8'h00);
      chk("add_wb", 32'({wb_valid, wb_rd, wb_data}), 32'({1'b1, 2'd0, 8'h08}));
      chk("sub_bypass_in1", 32'(alu_in1), 32'h08);
      idle();
      chk("sub_wb_data", 32'(wb_data), 32'h05);

      // Left shift of r1 by 2.
      load(2'd1, 8'h03);
      drive(1'b1, 9'h128, 1'b0, 2'd0, 8'h00);
      chk("lsl_ctrl", 32'({s_or_c, shift_dir, op_in}), 32'({1'b1, 1'b0, 4'd0}));
      chk("lsl_in2", 32'(alu_in2), 32'h02);
      idle();
      chk("lsl_wb", 32'({wb_valid, wb_rd, wb_data}), 32'({1'b1, 2'd1, 8'h0C}));

      // Illegal op followed by a reader of r0: no write, no forward.
      load(2'd0, 8'h05);
      load(2'd1, 8'h03);
      drive(1'b1, 9'h071, 1'b0, 2'd0, 8'h00);
      drive(1'b1, 9'h041, 1'b0, 2'd0, 8'h00);
      chk("ill_pulse", 32'({illegal, wb_valid}), 32'({1'b1, 1'b0}));
      chk("after_ill_in1", 32'(alu_in1), 32'h05);
      idle();
      chk("after_ill_wb", 32'(wb_data), 32'h08);

      // External write blocks issue; collision with a retire keeps ext data.
      load(2'd0, 8'h05);
      drive(1'b1, 9'h041, 1'b1, 2'd2, 8'h55);
      drive(1'b1, 9'h041, 1'b1, 2'd2, 8'h55);
      chk("held_no_accept", 32'(wb_valid), 32'd0);
      drive(1'b1, 9'h041, 1'b0, 2'd0, 8'h00);
      drive(1'b0, 9'h000, 1'b1, 2'd0, 8'hAA);
      chk("collide_wb", 32'({wb_valid, wb_data}), 32'({1'b1, 8'h08}));
      drive(1'b1, 9'h010, 1'b0, 2'd0, 8'h00);
      chk("collide_r0", 32'(alu_in1), 32'hAA);
      idle();

      // Reset in the cycle after accepting an ADD.
      load(2'd0, 8'h05);
      load(2'd1, 8'h03);
      drive(1'b1, 9'h041, 1'b0, 2'd0, 8'h00);
      instr_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      st1 = '0;
      st2 = '0;
      @(posedge clk);
      #1;
      chk("midrst_no_wb", 32'(wb_valid), 32'd0);
      rst_n = 1'b1;
      drive(1'b1, 9'h041, 1'b0, 2'd0, 8'h00);
      chk("post_rst_regs", 32'({alu_in1, alu_in2}), 32'd0);
      idle();

      // Random traffic against the architectural model.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, 9'($urandom), $urandom_range(0, 9) < 2,
               2'($urandom), 8'($urandom));
      end
      idle();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
